// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field positions and opcodes.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned DST_MSB = 11;
  localparam int unsigned DST_LSB = 6;
  localparam int unsigned SRC_MSB = 5;
  localparam int unsigned SRC_LSB = 0;

  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_MVI = 4'hC;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic {StRun, StHalt} fetch_state_e;

  function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decode instruction handshake: fetch is master, decode is slave.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
);
  logic               ir_valid;
  logic               ir_ready;
  logic [INSTR_W-1:0] ir_data;
  logic [ADDR_W-1:0]  ir_pc;

  modport master (output ir_valid, ir_data, ir_pc, input ir_ready);
  modport slave  (input ir_valid, ir_data, ir_pc, output ir_ready);
endinterface

// File: rtl/fetch_queue.sv
// Fall-through FIFO of {pc, instr}: a push into an empty queue is visible at the head
// in the same cycle. Synchronous flush has priority over push and pop.
module fetch_queue #(
  parameter int unsigned  ADDR_W  = 8,
  parameter int unsigned  INSTR_W = 16,
  parameter int unsigned  DEPTH   = 2,
  localparam int unsigned CntW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  output logic               valid,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [CntW-1:0]    count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               empty, do_push, do_pop, store, adv_rd;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    empty      = (count_q == '0);
    do_push    = push & ~flush;
    valid      = ~empty | do_push;
    do_pop     = pop & valid & ~flush;
    // A word bypassed to the head and popped in the same cycle is never stored.
    store      = do_push & ~(empty & do_pop);
    adv_rd     = do_pop & ~empty;
    head_pc    = empty ? push_pc : pc_mem[rd_ptr_q];
    head_instr = empty ? push_instr : instr_mem[rd_ptr_q];
    count      = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (adv_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(store) - CntW'(adv_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      pc_mem[wr_ptr_q]    <= push_pc;
      instr_mem[wr_ptr_q] <= push_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      a_no_overflow: assert (!(store && !adv_rd && count_q == CntW'(DEPTH)));
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues ROM reads, absorbs the one-cycle ROM latency and
// feeds decode through fetch_queue. Handles redirects and stops on HLT.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned      ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned      INSTR_W  = cpu_pkg::INSTR_W,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rom_read,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  instr_fetch_if.master      ir,
  output logic               halted
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, tag_q, tag_d;
  logic               inflight_q, inflight_d, discard_q, discard_d;

  logic               q_valid;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic [CntW-1:0]    q_count;
  logic               pop, push, hlt_push, issue;
  logic [CntW:0]      occupancy;

  fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (tag_q),
    .push_instr (rom_data),
    .pop        (pop),
    .valid      (q_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (q_count)
  );

  always_comb begin
    pop       = q_valid & ~rst & ir.ir_ready;
    push      = inflight_q & ~discard_q & ~redirect_valid & ~rst;
    hlt_push  = push & (get_opcode(rom_data) == OPC_HLT);
    // Queued words plus the returning read, less what decode takes this cycle.
    occupancy = {1'b0, q_count} + (CntW+1)'(inflight_q) - (CntW+1)'(pop);
    issue     = ~rst & (state_q == StRun) & ~redirect_valid
              & (occupancy < (CntW+1)'(DEPTH));

    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    discard_d  = 1'b0;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = StRun;
    end else begin
      if (issue) begin
        pc_d  = pc_q + ADDR_W'(1);
        tag_d = pc_q;
      end
      // The read issued alongside the HLT return is dropped; resume point is hlt_pc+1.
      if (hlt_push) begin
        state_d   = StHalt;
        pc_d      = tag_q + ADDR_W'(1);
        discard_d = issue;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  assign rom_read    = issue;
  assign rom_addr    = pc_q;
  assign halted      = (state_q == StHalt);
  assign ir.ir_valid = q_valid & ~rst;
  assign ir.ir_data  = (q_valid & ~rst) ? head_instr : '0;
  assign ir.ir_pc    = (q_valid & ~rst) ? head_pc : '0;

endmodule
